// File: rtl/gtxe2_chnl_pll_lockmon_if.sv
// Control and status bundle of the PLL lock monitor.
// The master drives the controls and fb_tick; the slave reports lock status.
interface gtxe2_chnl_pll_lockmon_if #(
  parameter int unsigned CW = 16
) ();
  logic          pd;
  logic          lock_en;
  logic          fb_tick;
  logic          locked;
  logic          fb_lost;
  logic          lock_lost;
  logic [1:0]    state;
  logic [CW-1:0] win_count;

  modport master (
    output pd, lock_en, fb_tick,
    input  locked, fb_lost, lock_lost, state, win_count
  );

  modport slave (
    input  pd, lock_en, fb_tick,
    output locked, fb_lost, lock_lost, state, win_count
  );
endinterface

// File: rtl/gtxe2_chnl_pll_lockmon.sv
// PLL lock monitor: counts feedback ticks per fixed ref_clk window and declares
// lock after enough consecutive good windows, dropping it after enough bad ones.
module gtxe2_chnl_pll_lockmon #(
  parameter int unsigned WINDOW         = 256,
  parameter int unsigned EXPECTED       = 128,
  parameter int unsigned TOLERANCE      = 2,
  parameter int unsigned LOCK_WINDOWS   = 3,
  parameter int unsigned UNLOCK_WINDOWS = 2,
  parameter int unsigned STARTUP        = 16,
  parameter int unsigned CW             = 16
) (
  input  logic                     ref_clk,
  input  logic                     reset,
  gtxe2_chnl_pll_lockmon_if.slave  bus
);

  localparam int unsigned GW = (LOCK_WINDOWS > 1) ? $clog2(LOCK_WINDOWS + 1) : 1;
  localparam int unsigned BW = (UNLOCK_WINDOWS > 1) ? $clog2(UNLOCK_WINDOWS + 1) : 1;
  // Bounds held in 32 bits so EXPECTED-TOLERANCE never wraps.
  localparam int unsigned LO = (EXPECTED > TOLERANCE) ? (EXPECTED - TOLERANCE) : 0;
  localparam int unsigned HI = EXPECTED + TOLERANCE;

  typedef enum logic [1:0] {
    StOff  = 2'd0,
    StWait = 2'd1,
    StAcq  = 2'd2,
    StLock = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] startup_q, startup_d;
  logic [CW-1:0] pos_q, pos_d;
  logic [CW-1:0] tick_q, tick_d;
  logic [CW-1:0] win_q, win_d;
  logic [GW-1:0] good_q, good_d;
  logic [BW-1:0] bad_q, bad_d;
  logic          fb_lost_q, fb_lost_d;
  logic          lock_lost_q, lock_lost_d;

  logic [CW-1:0] cnt;
  logic [31:0]   cnt_ext;
  logic          win_close;
  logic          win_good;
  logic [GW-1:0] good_inc;
  logic [BW-1:0] bad_inc;

  always_comb begin
    cnt       = tick_q + {{(CW-1){1'b0}}, bus.fb_tick};
    cnt_ext   = 32'(cnt);
    win_close = (pos_q == CW'(WINDOW - 1));
    win_good  = (cnt_ext >= LO) && (cnt_ext <= HI);
    good_inc  = (good_q == GW'(LOCK_WINDOWS)) ? good_q : good_q + GW'(1);
    bad_inc   = (bad_q == BW'(UNLOCK_WINDOWS)) ? bad_q : bad_q + BW'(1);

    state_d     = state_q;
    startup_d   = startup_q;
    pos_d       = pos_q;
    tick_d      = tick_q;
    win_d       = win_q;
    good_d      = good_q;
    bad_d       = bad_q;
    fb_lost_d   = fb_lost_q;
    lock_lost_d = 1'b0;

    if (bus.pd) begin
      state_d   = StOff;
      startup_d = '0;
      pos_d     = '0;
      tick_d    = '0;
      win_d     = '0;
      good_d    = '0;
      bad_d     = '0;
      fb_lost_d = 1'b0;
    end else begin
      unique case (state_q)
        StOff: begin
          state_d   = StWait;
          startup_d = '0;
        end
        StWait: begin
          if (startup_q == CW'(STARTUP - 1)) begin
            state_d = StAcq;
            pos_d   = '0;
            tick_d  = '0;
          end else begin
            startup_d = startup_q + CW'(1);
          end
        end
        StAcq, StLock: begin
          if (!bus.lock_en) begin
            // Forced restart: no window evaluation and no lock_lost pulse.
            state_d = StAcq;
            pos_d   = '0;
            tick_d  = '0;
            good_d  = '0;
            bad_d   = '0;
          end else if (win_close) begin
            pos_d     = '0;
            tick_d    = '0;
            win_d     = cnt;
            fb_lost_d = (cnt == '0);
            if (state_q == StAcq) begin
              if (win_good) begin
                good_d = good_inc;
                if (good_inc == GW'(LOCK_WINDOWS)) begin
                  state_d = StLock;
                  bad_d   = '0;
                end
              end else begin
                good_d = '0;
              end
            end else begin
              if (!win_good) begin
                bad_d = bad_inc;
                if (bad_inc == BW'(UNLOCK_WINDOWS)) begin
                  state_d     = StAcq;
                  lock_lost_d = 1'b1;
                  good_d      = '0;
                  bad_d       = '0;
                end
              end else begin
                bad_d = '0;
              end
            end
          end else begin
            pos_d  = pos_q + CW'(1);
            tick_d = cnt;
          end
        end
        default: state_d = StOff;
      endcase
    end
  end

  always_ff @(posedge ref_clk or posedge reset) begin
    if (reset) begin
      state_q     <= StOff;
      startup_q   <= '0;
      pos_q       <= '0;
      tick_q      <= '0;
      win_q       <= '0;
      good_q      <= '0;
      bad_q       <= '0;
      fb_lost_q   <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      startup_q   <= startup_d;
      pos_q       <= pos_d;
      tick_q      <= tick_d;
      win_q       <= win_d;
      good_q      <= good_d;
      bad_q       <= bad_d;
      fb_lost_q   <= fb_lost_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  assign bus.locked    = (state_q == StLock);
  assign bus.fb_lost   = fb_lost_q;
  assign bus.lock_lost = lock_lost_q;
  assign bus.state     = state_q;
  assign bus.win_count = win_q;

endmodule

// File: tb/tb_gtxe2_chnl_pll_lockmon.sv
// Directed bench for the PLL lock monitor with a 16-cycle window, 8 nominal ticks.
module tb_gtxe2_chnl_pll_lockmon;

  logic ref_clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;
  int   ll_count = 0;

  gtxe2_chnl_pll_lockmon_if #(.CW(16)) bus ();

  gtxe2_chnl_pll_lockmon #(
    .WINDOW        (16),
    .EXPECTED      (8),
    .TOLERANCE     (1),
    .LOCK_WINDOWS  (3),
    .UNLOCK_WINDOWS(2),
    .STARTUP       (4),
    .CW            (16)
  ) dut (
    .ref_clk(ref_clk),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 ref_clk = ~ref_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive fb_tick for one cycle, advance one edge, sample 1ns after it.
  task automatic cyc(input logic ft);
    bus.fb_tick = ft;
    @(posedge ref_clk);
    #1;
    if (bus.lock_lost === 1'b1) ll_count++;
  endtask

  // One full window; alt gives a tick every second cycle, else the first `ticks` cycles.
  task automatic window(input int ticks, input bit alt);
    for (int p = 0; p < 16; p++) cyc(alt ? (p % 2 == 1) : (p < ticks));
  endtask

  // Next edge is edge 1 after reset release or pd drop.
  task automatic relock(input string tag);
    cyc(1'b0);
    check({tag, "_e1_wait"}, 32'(bus.state), 32'd1);
    cyc(1'b0); cyc(1'b0); cyc(1'b0);
    check({tag, "_e4_wait"}, 32'(bus.state), 32'd1);
    cyc(1'b0);
    check({tag, "_e5_acq"}, 32'(bus.state), 32'd2);
    window(8, 1'b1);
    check({tag, "_w1_state"}, 32'(bus.state), 32'd2);
    check({tag, "_w1_count"}, 32'(bus.win_count), 32'd8);
    window(8, 1'b1);
    check({tag, "_e37_unlocked"}, 32'(bus.locked), 32'd0);
    window(8, 1'b1);
    check({tag, "_e53_locked"}, 32'(bus.locked), 32'd1);
    check({tag, "_e53_state"}, 32'(bus.state), 32'd3);
    check({tag, "_e53_count"}, 32'(bus.win_count), 32'd8);
  endtask

  initial begin
    reset       = 1'b1;
    bus.pd      = 1'b0;
    bus.lock_en = 1'b1;
    bus.fb_tick = 1'b0;
    cyc(1'b0); cyc(1'b0);
    check("rst_state", 32'(bus.state), 32'd0);
    check("rst_outs", {29'd0, bus.locked, bus.fb_lost, bus.lock_lost}, 32'd0);
    check("rst_count", 32'(bus.win_count), 32'd0);
    reset = 1'b0;

    relock("acq");

    // Feedback stops: fb_lost after the first window, lock dropped after the second.
    ll_count = 0;
    window(0, 1'b0);
    check("stop1_fb_lost", 32'(bus.fb_lost), 32'd1);
    check("stop1_count", 32'(bus.win_count), 32'd0);
    check("stop1_locked", 32'(bus.locked), 32'd1);
    window(0, 1'b0);
    check("stop2_locked", 32'(bus.locked), 32'd0);
    check("stop2_state", 32'(bus.state), 32'd2);
    check("stop2_pulse", 32'(bus.lock_lost), 32'd1);
    window(8, 1'b0);
    check("stop_pulse_count", 32'(ll_count), 32'd1);
    check("stop_fb_back", 32'(bus.fb_lost), 32'd0);
    window(8, 1'b0);
    window(8, 1'b0);
    check("relock_after_stop", 32'(bus.locked), 32'd1);

    // Alternating bad/good windows never accumulate two consecutive bad ones.
    ll_count = 0;
    window(10, 1'b0);
    check("alt_count10", 32'(bus.win_count), 32'd10);
    window(8, 1'b0);
    window(10, 1'b0);
    window(8, 1'b0);
    check("alt_locked", 32'(bus.locked), 32'd1);
    check("alt_no_pulse", 32'(ll_count), 32'd0);

    // Tolerance edges: 7 and 9 good; 10 then 6 are both bad and drop lock.
    window(7, 1'b0);
    window(9, 1'b0);
    check("tol_9_locked", 32'(bus.locked), 32'd1);
    window(10, 1'b0);
    check("tol_10_locked", 32'(bus.locked), 32'd1);
    window(6, 1'b0);
    check("tol_6_dropped", 32'(bus.state), 32'd2);

    // A bad window after two good ones restarts acquisition.
    window(8, 1'b0);
    window(8, 1'b0);
    window(10, 1'b0);
    window(8, 1'b0);
    window(8, 1'b0);
    check("acq_restart_not_yet", 32'(bus.state), 32'd2);
    window(8, 1'b0);
    check("acq_restart_locked", 32'(bus.state), 32'd3);

    // lock_en low for one cycle: back to ACQ silently, window restarts.
    ll_count = 0;
    bus.lock_en = 1'b0;
    cyc(1'b0);
    bus.lock_en = 1'b1;
    check("en_state", 32'(bus.state), 32'd2);
    check("en_pulse", 32'(bus.lock_lost), 32'd0);
    window(8, 1'b1);
    window(8, 1'b1);
    window(8, 1'b1);
    check("en_relock", 32'(bus.locked), 32'd1);
    check("en_no_pulse", 32'(ll_count), 32'd0);

    // pd for one cycle while locked.
    window(5, 1'b0);
    bus.pd = 1'b1;
    cyc(1'b0);
    bus.pd = 1'b0;
    check("pd_state", 32'(bus.state), 32'd0);
    check("pd_outs", {29'd0, bus.locked, bus.fb_lost, bus.lock_lost}, 32'd0);
    check("pd_count", 32'(bus.win_count), 32'd0);
    relock("pd");

    // Asynchronous reset mid-window, between clock edges.
    window(0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b1);
    #2 reset = 1'b1;
    #1;
    check("arst_state", 32'(bus.state), 32'd0);
    check("arst_outs", {29'd0, bus.locked, bus.fb_lost, bus.lock_lost}, 32'd0);
    check("arst_count", 32'(bus.win_count), 32'd0);
    #1 reset = 1'b0;
    relock("arst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
